// File: rtl/pll_usb_supervisor.sv
// USB PLL supervisor: pulses the PLL reset, waits for a stable lock, then releases the
// USB-domain reset. Failed lock attempts are retried, and lock loss and give-up are reported.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_PULSE_CYCLES cycles
// WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT_CYCLES for locked_s
// STABILISE | lock seen; counting LOCK_STABLE_CYCLES consecutive locked cycles
// RUN       | lock stable, USB domain out of reset, ready high
// FAIL      | MAX_ATTEMPTS consecutive timeouts; PLL held in reset until restart/rst
module pll_usb_supervisor #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 5000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_ATTEMPTS        = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       usb_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [7:0] retry_count
);

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                      : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       MAX_TRY  = 8'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILISE = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       retry_inc;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pll_rst_q, pll_rst_d;
    logic             usb_reset_q, usb_reset_d;
    logic             ready_q, ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic             fail_q, fail_d;
    logic             locked_s;

    assign locked_s  = sync2_q;
    assign retry_inc = retry_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        fail_d      = fail_q;
        lock_lost_d = 1'b0;
        sync1_d     = pll_locked;
        sync2_d     = sync1_q;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABILISE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    if (retry_inc == MAX_TRY) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_RESET_PLL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABILISE: begin
                // A dropout here is a glitch, not a failed attempt: retry_count is kept.
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = S_RESET_PLL;
                    cnt_d       = '0;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Restart overrides the transition but not a lock_lost pulse from RUN.
        if (restart) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            fail_d  = 1'b0;
        end

        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        usb_reset_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            usb_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pll_rst_q   <= pll_rst_d;
            usb_reset_q <= usb_reset_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign usb_reset   = usb_reset_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule
